// File: rtl/mad_pkg.sv
// rtl/mad_pkg.sv - shared defaults and helpers for the MAD processor output path
package mad_pkg;

  // Processor Out port word width and default output FIFO depth
  localparam int WORD_W         = 16;
  localparam int OUT_FIFO_DEPTH = 8;

  // Width of the optional dropped-word counter
  localparam int OVF_CNT_W      = 8;

  // Saturating increment for the dropped-word counter
  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + 1'b1;
  endfunction

endpackage

// File: rtl/mad_fifo_mem.sv
// rtl/mad_fifo_mem.sv - DEPTH x WIDTH storage, one write port, one asynchronous read port
module mad_fifo_mem #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage is intentionally unreset; only the pointers define what is valid
  always_ff @(posedge Clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mad_out_port_fifo.sv
// rtl/mad_out_port_fifo.sv - processor Out port FIFO; optional MAD_OUT_FIFO_OVF_CNT_EN adds ovf_cnt
module mad_out_port_fifo
  import mad_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = OUT_FIFO_DEPTH
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic [WIDTH-1:0]         out_data,
  input  logic                     out_we,
  output logic [WIDTH-1:0]         m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     ovf,
  input  logic                     ovf_clr
`ifdef MAD_OUT_FIFO_OVF_CNT_EN
  ,
  output logic [OVF_CNT_W-1:0]     ovf_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          ovf_q,    ovf_d;

  logic pop;
  logic push;
  logic drop;

  assign full    = (count_q == CW'(DEPTH));
  assign m_valid = (count_q != '0);
  assign count   = count_q;
  assign ovf     = ovf_q;

  // A pop frees a slot in the same cycle, so a write at full is still taken
  assign pop  = m_valid && m_ready;
  assign push = out_we && (!full || pop);
  assign drop = out_we && full && !pop;

  mad_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .Clk     (Clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (out_data),
    .raddr_i (rd_ptr_q),
    .rdata_o (m_data)
  );

  // Next-state for pointers, occupancy and the sticky overflow flag
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // A new overflow takes priority over a coincident clear
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  // State register; reset discards all queued words immediately
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef MAD_OUT_FIFO_OVF_CNT_EN
  logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  // Dropped-word counter, saturating; increment wins over a coincident clear
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop) begin
      ovf_cnt_d = sat_inc(ovf_cnt_q);
    end else if (ovf_clr) begin
      ovf_cnt_d = '0;
    end
  end

  // Dropped-word counter register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      ovf_cnt_q <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_mad_out_port_fifo.sv
// tb/tb_mad_out_port_fifo.sv - directed self-checking bench for mad_out_port_fifo
module tb_mad_out_port_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 8;

  logic             Clk = 1'b0;
  logic             Rst;
  logic [WIDTH-1:0] out_data;
  logic             out_we;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [3:0]       count;
  logic             full;
  logic             ovf;
  logic             ovf_clr;
`ifdef MAD_OUT_FIFO_OVF_CNT_EN
  logic [7:0]       ovf_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 Clk = ~Clk;

  mad_out_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .out_data (out_data),
    .out_we   (out_we),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .count    (count),
    .full     (full),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
`ifdef MAD_OUT_FIFO_OVF_CNT_EN
    ,
    .ovf_cnt  (ovf_cnt)
`endif
  );

  // One clock edge; inputs change and outputs are sampled 1 time unit after it
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_word(input logic [WIDTH-1:0] d);
    out_we   = 1'b1;
    out_data = d;
    tick();
    out_we   = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0; out_we = 1'b0; out_data = '0; m_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    total++; if (m_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", m_valid); else passed++;
    total++; if (count !== 4'd0) $display("FAIL reset_count got=%0d exp=0", count); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full got=%b exp=0", full); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got=%b exp=0", ovf); else passed++;
    Rst = 1'b1;
    tick();
  endtask

  task automatic test_single();
    write_word(16'h0019);
    total++; if (m_valid !== 1'b1) $display("FAIL single_valid got=%b exp=1", m_valid); else passed++;
    total++; if (m_data !== 16'h0019) $display("FAIL single_data got=%h exp=0019", m_data); else passed++;
    total++; if (count !== 4'd1) $display("FAIL single_count got=%0d exp=1", count); else passed++;
    tick();
    total++; if (m_data !== 16'h0019) $display("FAIL single_hold got=%h exp=0019", m_data); else passed++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL single_drain got=%b exp=0", m_valid); else passed++;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) write_word(16'h0010 + 16'(i));
    total++; if (full !== 1'b1) $display("FAIL fullpop_full got=%b exp=1", full); else passed++;
    out_we = 1'b1; out_data = 16'hF320; m_ready = 1'b1;
    tick();
    out_we = 1'b0; m_ready = 1'b0;
    total++; if (count !== 4'd8) $display("FAIL fullpop_count got=%0d exp=8", count); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL fullpop_ovf got=%b exp=0", ovf); else passed++;
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [WIDTH-1:0] e;
      e = (i == 7) ? 16'hF320 : 16'h0011 + 16'(i);
      total++; if (m_data !== e) $display("FAIL fullpop_drain%0d got=%h exp=%h", i, m_data, e); else passed++;
      tick();
    end
    m_ready = 1'b0;
    total++; if (count !== 4'd0) $display("FAIL fullpop_empty got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 8; i++) write_word(16'(i));
    total++; if (full !== 1'b1) $display("FAIL ovf_full got=%b exp=1", full); else passed++;
    total++; if (count !== 4'd8) $display("FAIL ovf_count8 got=%0d exp=8", count); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL ovf_pre got=%b exp=0", ovf); else passed++;
    write_word(16'hFFFF);
    total++; if (ovf !== 1'b1) $display("FAIL ovf_set got=%b exp=1", ovf); else passed++;
    total++; if (count !== 4'd8) $display("FAIL ovf_count_hold got=%0d exp=8", count); else passed++;
`ifdef MAD_OUT_FIFO_OVF_CNT_EN
    total++; if (ovf_cnt !== 8'd1) $display("FAIL ovf_cnt1 got=%0d exp=1", ovf_cnt); else passed++;
`endif
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      total++; if (m_data !== 16'(i)) $display("FAIL ovf_drain%0d got=%h exp=%h", i, m_data, 16'(i)); else passed++;
      tick();
    end
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL ovf_empty got=%b exp=0", m_valid); else passed++;
    total++; if (ovf !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", ovf); else passed++;
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    total++; if (ovf !== 1'b0) $display("FAIL clr_ovf got=%b exp=0", ovf); else passed++;
`ifdef MAD_OUT_FIFO_OVF_CNT_EN
    total++; if (ovf_cnt !== 8'd0) $display("FAIL clr_cnt got=%0d exp=0", ovf_cnt); else passed++;
`endif
    for (int i = 0; i < 8; i++) write_word(16'h0100 + 16'(i));
    out_we = 1'b1; out_data = 16'hDEAD; ovf_clr = 1'b1;
    tick();
    out_we = 1'b0; ovf_clr = 1'b0;
    total++; if (ovf !== 1'b1) $display("FAIL clr_coincide got=%b exp=1", ovf); else passed++;
`ifdef MAD_OUT_FIFO_OVF_CNT_EN
    total++; if (ovf_cnt !== 8'd1) $display("FAIL clr_coincide_cnt got=%0d exp=1", ovf_cnt); else passed++;
`endif
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    m_ready = 1'b0;
    total++; if (count !== 4'd0) $display("FAIL clr_drain got=%0d exp=0", count); else passed++;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] exp_q[$];
    int sent = 0;
    int got  = 0;
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      out_we   = (cyc % 2 == 0) && (sent < 20);
      out_data = 16'h0111 * 16'(sent) + 16'h0003;
      m_ready  = (cyc % 2 == 0);
      #1;
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) $display("FAIL stream_extra got=%h exp=none", m_data);
        else if (m_data !== exp_q[0]) $display("FAIL stream_word%0d got=%h exp=%h", got, m_data, exp_q[0]);
        else passed++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        got++;
      end
      if (out_we) begin
        exp_q.push_back(out_data);
        sent++;
      end
      tick();
    end
    out_we = 1'b0; m_ready = 1'b0;
    total++; if (got !== 20) $display("FAIL stream_total got=%0d exp=20", got); else passed++;
    total++; if (count !== 4'd0) $display("FAIL stream_empty got=%0d exp=0", count); else passed++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) write_word(16'h0500 + 16'(i));
    total++; if (count !== 4'd5) $display("FAIL arst_pre got=%0d exp=5", count); else passed++;
    #2;
    Rst = 1'b0;
    #1;
    total++; if (m_valid !== 1'b0) $display("FAIL arst_valid got=%b exp=0", m_valid); else passed++;
    total++; if (count !== 4'd0) $display("FAIL arst_count got=%0d exp=0", count); else passed++;
    tick();
    Rst = 1'b1;
    tick();
    write_word(16'hAABD);
    total++; if (m_data !== 16'hAABD) $display("FAIL arst_head got=%h exp=AABD", m_data); else passed++;
    total++; if (count !== 4'd1) $display("FAIL arst_count1 got=%0d exp=1", count); else passed++;
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    total++; if (m_valid !== 1'b0) $display("FAIL arst_alone got=%b exp=0", m_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_full_pop();
    test_overflow();
    test_ovf_clr();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mad_out_port_fifo.md
MAD_OUT_PORT_FIFO -- requirements
Module: mad_out_port_fifo

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data word width and match the processor Out port.
REQ-002 Parameter DEPTH, default 8, power of two >= 2, SHALL set the number of FIFO entries.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 out_data  input  WIDTH  SHALL carry the processor Out value to be queued.
REQ-006 out_we  input  1  SHALL be the processor OUT-instruction strobe, one cycle per word.
REQ-007 m_data  output  WIDTH  SHALL present the head-of-queue word to the external sink.
REQ-008 m_valid  output  1  SHALL be high when m_data holds a valid word.
REQ-009 m_ready  input  1  SHALL signal sink acceptance; a transfer occurs when m_valid && m_ready.
REQ-010 count  output  $clog2(DEPTH)+1  SHALL report current occupancy.
REQ-011 full  output  1  SHALL be high when count == DEPTH.
REQ-012 ovf  output  1  SHALL be the sticky overflow flag.
REQ-013 ovf_clr  input  1  SHALL clear ovf synchronously.

Function
REQ-014 A write SHALL be accepted when out_we && (!full || pop), where pop = m_valid && m_ready.
REQ-015 Accepted data SHALL be stored at the write pointer, and the write pointer SHALL increment modulo DEPTH.
REQ-016 A pop SHALL advance the read pointer modulo DEPTH.
REQ-017 m_data SHALL be driven combinationally from the entry at the read pointer, and m_valid SHALL equal (count != 0).
REQ-018 No empty-bypass: a word written into an empty FIFO SHALL appear on m_valid/m_data in the next cycle, giving 1-cycle latency.
REQ-019 When a write and a pop occur in the same cycle, count SHALL stay unchanged, including at full.
REQ-020 When out_we is high while full and no pop occurs, the word SHALL be dropped, pointers SHALL stay unchanged, and ovf SHALL be set the next cycle.
REQ-021 m_data/m_valid SHALL stay stable while m_valid && !m_ready.
REQ-022 When ovf_clr and an overflow coincide, the set SHALL win.
REQ-023 Pointer wrap SHALL be seamless across DEPTH boundaries, with no lost or duplicated entries.

Reset
REQ-024 While Rst is low, the pointers and count SHALL be 0, m_valid 0, full 0, ovf 0, and m_data SHALL read the value stored at entry 0.
REQ-025 Storage array contents SHALL NOT require reset.
REQ-026 Asserting Rst mid-operation SHALL discard all queued words immediately, without waiting for a clock edge.

Configuration
REQ-027 With macro MAD_OUT_FIFO_OVF_CNT_EN defined, an 8-bit output ovf_cnt SHALL count dropped words, saturate at 255, reset to 0, and clear on ovf_clr.
REQ-028 Without MAD_OUT_FIFO_OVF_CNT_EN, the ovf_cnt port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-029 The shared package mad_pkg SHALL hold WORD_W = 16 and OUT_FIFO_DEPTH = 8 as defaults.
REQ-030 A single sub-module, mad_fifo_mem (DEPTH x WIDTH, one write port, one asynchronous read port), SHALL hold storage; pointer, count and flag logic stays in the top module.

Verification
REQ-031 Reset, then out_we with data 0x0019 and m_ready=0 -> m_valid=1 and m_data=0x0019 one cycle later; count=1.
REQ-032 Write 0x0001..0x0008 with m_ready=0 -> full=1, count=8; a 9th write of 0xFFFF -> dropped, ovf=1, ovf_cnt=1 (macro on); drain returns 0x0001..0x0008 in order.
REQ-033 At full, out_we=1 with 0xF320 and m_ready=1 in the same cycle -> count stays 8, ovf stays 0, 0xF320 is the last word drained.
REQ-034 Stream 20 words with m_ready toggling every cycle -> the output sequence equals the input sequence with no loss across pointer wrap.
REQ-035 With 5 words queued, drop Rst low mid-cycle -> m_valid=0 and count=0 immediately; after release, a write of 0xAABD appears alone at the head.
REQ-036 With ovf=1, pulse ovf_clr -> ovf=0 the next cycle; ovf_clr coincident with an overflowing write -> ovf=1.
